// File: rtl/fib_pkg.sv
// Shared definitions for the additive-sequence generator.
// Ports: none (package).
// Holds the overflow-mode encodings and the FSM state type.
package fib_pkg;

    localparam logic [1:0] MODE_WRAP = 2'b00;
    localparam logic [1:0] MODE_SAT  = 2'b01;
    localparam logic [1:0] MODE_HALT = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fib_state_e;

endpackage

// File: rtl/fib_sat_add.sv
// Purpose : WIDTH+1-bit adder with optional saturation of the WIDTH-bit result.
// Latency : combinational.
// Ports   : a, b (addends), sat (clamp on carry) -> sum (WIDTH bits), carry.
module fib_sat_add #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sat,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0] full_sum;

    assign full_sum = {1'b0, a} + {1'b0, b};
    assign carry    = full_sum[WIDTH];
    assign sum      = (sat && carry) ? {WIDTH{1'b1}} : full_sum[WIDTH-1:0];

endmodule

// File: rtl/fib_seq_gen.sv
// Purpose : streams num_terms terms of t(n)=t(n-1)+t(n-2) from two seeds, with wrap/saturate/halt overflow handling.
// Latency : first term valid one cycle after start; one term per cycle while out_ready is high.
// Ports   : start/seed0/seed1/num_terms/mode in; out_valid/out_ready/out_data/out_last stream; busy, done pulse, sticky overflow.
module fib_seq_gen
    import fib_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    input  logic [CNT_W-1:0] num_terms,
    input  logic [1:0]       mode,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    fib_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             b_ovf_q, b_ovf_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] nterm_q, nterm_d;
    logic [1:0]       mode_q, mode_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic             run;
    logic             hs;
    logic             last;
    logic [WIDTH-1:0] add_sum;
    logic             add_carry;

    // Mode 11 falls through to plain wrap: only SAT clamps, only HALT cuts short.
    fib_sat_add #(.WIDTH(WIDTH)) u_add (
        .a     (a_q),
        .b     (b_q),
        .sat   (mode_q == MODE_SAT),
        .sum   (add_sum),
        .carry (add_carry)
    );

    assign run  = (state_q == ST_RUN);
    assign hs   = run && out_ready;
    // In halt mode the beat whose successor was produced by a carrying sum is the final one.
    assign last = run && ((idx_q == (nterm_q - CNT_ONE)) ||
                          ((mode_q == MODE_HALT) && b_ovf_q));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        b_ovf_d = b_ovf_q;
        idx_d   = idx_q;
        nterm_d = nterm_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = seed0;
                    b_d     = seed1;
                    b_ovf_d = 1'b0;
                    idx_d   = '0;
                    nterm_d = num_terms;
                    mode_d  = mode;
                    ovf_d   = 1'b0;
                    if (num_terms != '0) begin
                        state_d = ST_RUN;
                    end else begin
                        // Empty run: nothing to stream, just signal completion.
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (hs) begin
                    a_d     = b_q;
                    b_d     = add_sum;
                    b_ovf_d = add_carry;
                    ovf_d   = ovf_q | add_carry;
                    idx_d   = idx_q + CNT_ONE;
                    if (last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            b_ovf_q <= 1'b0;
            idx_q   <= '0;
            nterm_q <= '0;
            mode_q  <= MODE_WRAP;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            b_ovf_q <= b_ovf_d;
            idx_q   <= idx_d;
            nterm_q <= nterm_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign out_valid = run;
    assign out_data  = a_q;
    assign out_last  = last;
    assign busy      = run;
    assign done      = done_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Testbench for fib_seq_gen: directed runs from the test plan plus randomized runs,
// each stream compared beat by beat against an arithmetic reference of the sequence.
// Ports: none (top-level bench).
module tb_fib_seq_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] seed0;
    logic [9:0] seed1;
    logic [7:0] num_terms;
    logic [1:0] mode;
    logic       out_ready;
    logic       out_valid;
    logic [9:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    fib_seq_gen #(.WIDTH(10), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seed0     (seed0),
        .seed1     (seed1),
        .num_terms (num_terms),
        .mode      (mode),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // rdy_mode: 0 = ready always high, 1 = ready pattern 1,0,0 repeating, 2 = random.
    // noise: drive random start/seed/count/mode values during the run (all must be ignored).
    task automatic run_seq(input int s0, input int s1, input int n, input int md,
                           input int rdy_mode, input bit noise, input string tag);
        int  t[0:300];
        bit  c[0:300];
        int  nexp;
        bit  exp_ovf;
        int  k;
        int  cyc;
        int  sm;
        bit  rdy;
        bit  halt;

        // Reference: the sequence itself, with each term flagged if its defining sum exceeded 1023.
        halt = (md == 2);
        t[0] = s0;
        t[1] = s1;
        c[0] = 1'b0;
        c[1] = 1'b0;
        for (int j = 2; j <= n + 1; j++) begin
            sm   = t[j-2] + t[j-1];
            c[j] = (sm > 1023);
            if (c[j]) t[j] = (md == 1) ? 1023 : sm - 1024;
            else      t[j] = sm;
        end
        nexp = n;
        for (int j = 0; j < n; j++) begin
            if (halt && c[j+1]) begin
                nexp = j + 1;
                break;
            end
        end
        // Each emitted beat j triggers the sum that defines term j+2.
        exp_ovf = 1'b0;
        for (int j = 0; j < nexp; j++) exp_ovf = exp_ovf | c[j+2];

        @(negedge clk);
        seed0     = 10'(s0);
        seed1     = 10'(s1);
        num_terms = 8'(n);
        mode      = 2'(md);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;

        k   = 0;
        cyc = 0;
        while (k < nexp && cyc < 1000) begin
            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 3) == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (noise) begin
                start     = 1'($urandom_range(0, 1));
                seed0     = 10'($urandom);
                seed1     = 10'($urandom);
                num_terms = 8'($urandom);
                mode      = 2'($urandom);
            end
            check({tag, " valid"}, 32'(out_valid), 32'd1);
            check({tag, " busy"},  32'(busy),      32'd1);
            check({tag, " data"},  32'(out_data),  32'(t[k]));
            check({tag, " last"},  32'(out_last),  32'(k == nexp - 1));
            check({tag, " done_in_run"}, 32'(done), 32'd0);
            if (rdy) k++;
            cyc++;
            @(negedge clk);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        if (k < nexp) check({tag, " timeout beats"}, 32'(k), 32'(nexp));
        check({tag, " done_pulse"}, 32'(done),      32'd1);
        check({tag, " busy_end"},   32'(busy),      32'd0);
        check({tag, " valid_end"},  32'(out_valid), 32'd0);
        check({tag, " overflow"},   32'(overflow),  32'(exp_ovf));
        @(negedge clk);
        check({tag, " done_low"},   32'(done),      32'd0);
        check({tag, " ovf_hold"},   32'(overflow),  32'(exp_ovf));
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        start     = 1'b0;
        seed0     = '0;
        seed1     = '0;
        num_terms = '0;
        mode      = '0;
        out_ready = 1'b1;

        // Reset state
        #12;
        check("rst valid", 32'(out_valid), 32'd0);
        check("rst data",  32'(out_data),  32'd0);
        check("rst last",  32'(out_last),  32'd0);
        check("rst busy",  32'(busy),      32'd0);
        check("rst done",  32'(done),      32'd0);
        check("rst ovf",   32'(overflow),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed runs from the plan
        run_seq(0, 1, 10, 0, 0, 1'b0, "fib10");
        run_seq(0, 1, 20, 0, 0, 1'b0, "wrap20");
        run_seq(0, 1, 20, 1, 0, 1'b0, "sat20");
        run_seq(0, 1, 20, 2, 0, 1'b0, "halt20");
        run_seq(0, 1, 20, 3, 0, 1'b0, "mode3");
        run_seq(2, 1, 6,  0, 1, 1'b1, "lucas");

        // Zero-length run: no beats, done pulse next cycle
        @(negedge clk);
        num_terms = 8'd0;
        seed0     = 10'd5;
        seed1     = 10'd7;
        mode      = 2'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero done",  32'(done),      32'd1);
        check("zero valid", 32'(out_valid), 32'd0);
        check("zero busy",  32'(busy),      32'd0);
        @(negedge clk);
        check("zero done_low", 32'(done),      32'd0);
        check("zero valid2",   32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a run
        seed0     = 10'd0;
        seed1     = 10'd1;
        num_terms = 8'd20;
        mode      = 2'd1;
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid term5", 32'(out_data), 32'd5);
        #2 rst = 1'b1;
        #1;
        check("arst valid", 32'(out_valid), 32'd0);
        check("arst busy",  32'(busy),      32'd0);
        check("arst ovf",   32'(overflow),  32'd0);
        check("arst data",  32'(out_data),  32'd0);
        check("arst last",  32'(out_last),  32'd0);
        check("arst done",  32'(done),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_seq(0, 1, 12, 0, 0, 1'b0, "post_rst");

        // Randomized runs
        for (int r = 0; r < 12; r++) begin
            run_seq(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                    int'($urandom_range(1, 25)), int'($urandom_range(0, 3)),
                    2, 1'b1, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fib_seq_gen.md
# fib_seq_gen

Parametrised additive-sequence generator, successor to the free-running Fibonacci counter. On a `start` pulse it loads two seed terms, a term count and an overflow mode, then streams `num_terms` terms of the sequence t(n) = t(n-1) + t(n-2) over a valid/ready interface with a last-beat marker. It sits wherever a test-pattern or sequence source feeds a downstream consumer that applies backpressure.

## Interface
- `WIDTH`, 10: term width in bits.
- `CNT_W`, 8: width of the term counter and `num_terms`.
---
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `seed0`  in  WIDTH  t(0); captured on accepted `start`.
- `seed1`  in  WIDTH  t(1); captured on accepted `start`.
- `num_terms`  in  CNT_W  terms to emit; captured on accepted `start`.
- `mode`  in  2  00 wrap, 01 saturate, 10 halt-on-overflow, 11 treated as 00.
- `out_ready`  in  1  consumer ready.
- `out_valid`  out  1  `out_data` holds a term.
- `out_data`  out  WIDTH  current term.
- `out_last`  out  1  qualifies the final beat of the run.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse after the final handshake.
- `overflow`  out  1  sticky: an overflowing sum occurred in the current or last run.

## Operation
- FSM: IDLE, RUN. IDLE + `start` + `num_terms`>0 -> RUN; IDLE + `start` + `num_terms`==0 -> stay IDLE, `done` pulses next cycle, no beats.
- Registers: `a` (current term, drives `out_data`), `b` (next term), `b_ovf`, `idx` (CNT_W), `overflow`.
- On accepted start: a<=seed0, b<=seed1, b_ovf<=0, idx<=0, overflow<=0.
- `out_valid` = (state==RUN). Handshake = out_valid & out_ready.
- Per handshake: a<=b; sum = a+b computed WIDTH+1 wide; carry = sum[WIDTH]; b <= wrap: sum[WIDTH-1:0]; saturate: carry ? all-ones : sum[WIDTH-1:0]; halt: sum[WIDTH-1:0]. b_ovf<=carry; overflow<=overflow|carry; idx<=idx+1.
- `out_last` = RUN & ((idx == num_terms-1) | (mode==10 & b_ovf)).
- Handshake with `out_last` high -> IDLE; `done` pulses the following cycle.
- `start` in RUN ignored, including in the cycle of the final handshake.
- `out_data`/`out_last` stable while `out_valid` & !`out_ready`.

## Timing
- Reset values: state IDLE, `out_valid` 0, `out_data` 0, `out_last` 0, `busy` 0, `done` 0, `overflow` 0.
- Start-to-first-valid: 1 cycle (start sampled at edge k, `out_valid`=1 with t(0) after edge k).
- Throughput: one term per cycle with `out_ready` held high; no bubbles.
- `done` high exactly one cycle, the cycle after the final handshake; `busy` low in the same cycle.
- `rst` mid-run: all outputs return to reset values immediately (asynchronous); run discarded.
- `overflow` updates one cycle after the handshake that computed the carrying sum; holds until next accepted start.

## Structure
- Shared package `fib_pkg`: mode encodings (MODE_WRAP, MODE_SAT, MODE_HALT), FSM state typedef.
- Single module; the WIDTH+1 adder with wrap/saturate select is natural as sub-module `fib_sat_add`.

## Test plan
- WIDTH=10, seeds 0/1, num_terms=10, mode wrap, ready high -> 0,1,1,2,3,5,8,13,21,34 on consecutive cycles, `out_last` on 34, `done` next cycle, `overflow` 0.
- Seeds 0/1, num_terms=20, mode wrap -> t(16)=987, t(17)=573, t(18)=536, `overflow` 1 after run.
- Same, mode saturate -> t(16)=987, t(17)=1023, t(18)=1023, t(19)=1023, `out_last` on t(19).
- Same, mode halt -> 17 beats, last beat 987 with `out_last`, `done` next cycle, `overflow` 1.
- Seeds 2/1 (Lucas), num_terms=6, `out_ready` toggled 1,0,0,1,... -> 2,1,3,4,7,11, data held stable while stalled; `start` during RUN ignored; num_terms=0 -> no beats, `done` pulse.
- Assert `rst` at term 5 of a run -> `out_valid`, `busy`, `overflow` 0 immediately; next start runs cleanly from seeds.
